// File: rtl/bram_row_gather.sv
// Multi-row BRAM gather: walks a row-major matrix in single-port BRAM and presents
// each row as one zero-padded N-element vector behind a valid/ready handshake.
module bram_row_gather #(
   parameter int BIT_WIDTH     = 16,
   parameter int N             = 32,
   parameter int ADDR_WIDTH    = 10,
   parameter int ROW_CNT_WIDTH = 6,
   parameter int RD_LATENCY    = 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic [ADDR_WIDTH-1:0]              base_addr,
   input  logic [$clog2(N+1)-1:0]             row_len,
   input  logic [ROW_CNT_WIDTH-1:0]           num_rows,
   output logic                               bram_en,
   output logic [ADDR_WIDTH-1:0]              bram_addr,
   input  logic signed [BIT_WIDTH-1:0]        bram_dataA,
   output logic signed [N-1:0][BIT_WIDTH-1:0] o_data,
   output logic [ROW_CNT_WIDTH-1:0]           o_row,
   output logic                               o_valid,
   input  logic                               o_ready,
   output logic                               busy,
   output logic                               done
);
   localparam int LW = $clog2(N + 1);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_HOLD, S_DONE} state_t;

   state_t                        r_state;
   state_t                        w_next;
   logic [ADDR_WIDTH-1:0]         r_base;
   logic [ADDR_WIDTH-1:0]         r_row_base;
   logic [LW-1:0]                 r_len;
   logic [LW-1:0]                 r_col;
   logic [ROW_CNT_WIDTH-1:0]      r_rows;
   logic [DW-1:0]                 r_drain;
   logic [RD_LATENCY-1:0]         r_tag_vld;
   logic [RD_LATENCY-1:0][CW-1:0] r_tag_col;
   logic [LW-1:0]                 w_len;
   logic                          w_last;
   logic                          w_clear;

   assign w_len   = (row_len > LW'(N)) ? LW'(N) : row_len;
   assign w_last  = (o_row == r_rows - ROW_CNT_WIDTH'(1));
   assign w_clear = (w_next == S_ISSUE) && (r_state != S_ISSUE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = (row_len == '0 || num_rows == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (r_col == r_len - LW'(1)) w_next = S_DRAIN;
         S_DRAIN: if (r_drain == DW'(RD_LATENCY - 1)) w_next = S_HOLD;
         S_HOLD:  if (o_ready) w_next = w_last ? S_DONE : S_ISSUE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bram_en   = (r_state == S_ISSUE);
      bram_addr = bram_en ? (r_base + r_row_base + ADDR_WIDTH'(r_col)) : '0;
      o_valid   = (r_state == S_HOLD);
      busy      = (r_state != S_IDLE);
      done      = (r_state == S_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_base     <= '0;
         r_row_base <= '0;
         r_len      <= '0;
         r_col      <= '0;
         r_rows     <= '0;
         r_drain    <= '0;
         o_row      <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_base     <= base_addr;
               r_len      <= w_len;
               r_rows     <= num_rows;
               r_row_base <= '0;
               r_col      <= '0;
               o_row      <= '0;
            end
            S_ISSUE: begin
               r_col   <= r_col + LW'(1);
               r_drain <= '0;
            end
            S_DRAIN: r_drain <= r_drain + DW'(1);
            S_HOLD: if (o_ready) begin
               o_row      <= o_row + ROW_CNT_WIDTH'(1);
               r_row_base <= r_row_base + ADDR_WIDTH'(r_len);
               r_col      <= '0;
            end
            default: ;
         endcase
      end
   end

   // Tags shift in at the low end; the top stage lines up with bram_dataA.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tag_vld <= '0;
         r_tag_col <= '0;
         o_data    <= '0;
      end else begin
         r_tag_vld <= RD_LATENCY'({r_tag_vld, bram_en});
         r_tag_col <= (RD_LATENCY * CW)'({r_tag_col, r_col[CW-1:0]});
         if (w_clear)
            o_data <= '0;
         else if (r_tag_vld[RD_LATENCY-1])
            o_data[r_tag_col[RD_LATENCY-1]] <= bram_dataA;
      end
   end
endmodule

// File: tb/tb_bram_row_gather.sv
// Directed bench for bram_row_gather: three instances (read latency 1, 2, 3) share
// one stimulus stream; a per-cycle model derives every output from the job parameters.
module tb_bram_row_gather;
   localparam int BW = 16;
   localparam int N  = 32;
   localparam int AW = 10;
   localparam int RW = 6;
   localparam int LW = $clog2(N + 1);
   localparam int IW = $clog2(N);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, rdy;
   logic [AW-1:0] base;
   logic [LW-1:0] rlen;
   logic [RW-1:0] nrows;
   logic signed [BW-1:0] mem [0:(1<<AW)-1];

   logic                 en_a   [3];
   logic [AW-1:0]        addr_a [3];
   logic [N-1:0][BW-1:0] data_a [3];
   logic [RW-1:0]        row_a  [3];
   logic                 val_a  [3];
   logic                 busy_a [3];
   logic                 done_a [3];

   int cyc = 0;
   int checks = 0, errors = 0;
   int job_id = 0, job_e0 = 0, job_base = 0, job_len = 0, job_rows = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input int inst, input string nm, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL lat%0d %s: got %0d, expected %0d (cycle %0d)", inst + 1, nm, act, req, cyc);
      end
   endfunction

   function automatic int first_diff(input logic [N-1:0][BW-1:0] a, input logic [N-1:0][BW-1:0] b);
      for (int j = 0; j < N; j++)
         if (a[IW'(j)] != b[IW'(j)]) return j;
      return -1;
   endfunction

   function automatic void chkv(input int inst, input string nm, input logic [N-1:0][BW-1:0] act,
                                input logic [N-1:0][BW-1:0] req);
      int fd;
      fd = first_diff(act, req);
      checks++;
      if (fd >= 0) begin
         errors++;
         $display("FAIL lat%0d %s: element %0d is %0d, expected %0d (cycle %0d)", inst + 1, nm, fd,
                  $signed(act[IW'(fd)]), $signed(req[IW'(fd)]), cyc);
      end
   endfunction

   for (genvar g = 0; g < 3; g++) begin : gen_lat
      localparam int LAT = g + 1;
      logic signed [BW-1:0] pipe [LAT];
      logic signed [BW-1:0] dq;
      int seen = 0, e0 = 0, tref = 0, dedge = -1, len = 0, rows = 0, row = 0, base_q = 0;
      bit act = 1'b0, hold = 1'b0;

      // BRAM read port: data for an address appears LAT cycles later
      always @(posedge clk) begin
         pipe[0] <= en_a[g] ? mem[addr_a[g]] : 16'sh5A5A;
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign dq = pipe[LAT-1];

      bram_row_gather #(
         .BIT_WIDTH(BW), .N(N), .ADDR_WIDTH(AW), .ROW_CNT_WIDTH(RW), .RD_LATENCY(LAT)
      ) u_dut (
         .clk(clk), .rst(rst), .start(start), .base_addr(base), .row_len(rlen),
         .num_rows(nrows), .bram_en(en_a[g]), .bram_addr(addr_a[g]), .bram_dataA(dq),
         .o_data(data_a[g]), .o_row(row_a[g]), .o_valid(val_a[g]), .o_ready(rdy),
         .busy(busy_a[g]), .done(done_a[g])
      );

      always @(negedge clk) begin : compare
         logic [N-1:0][BW-1:0] ev;
         bit xen, xval, xbusy, xdone;
         int xaddr;
         if (rst) begin
            act = 1'b0; hold = 1'b0; seen = job_id;
            chk(g, "rst_en",    longint'(en_a[g]),   0);
            chk(g, "rst_addr",  longint'(addr_a[g]), 0);
            chk(g, "rst_valid", longint'(val_a[g]),  0);
            chk(g, "rst_busy",  longint'(busy_a[g]), 0);
            chk(g, "rst_done",  longint'(done_a[g]), 0);
            chk(g, "rst_row",   longint'(row_a[g]),  0);
            chkv(g, "rst_data", data_a[g], '0);
         end else begin
            if (job_id != seen) begin
               seen = job_id; act = 1'b1; e0 = job_e0; base_q = job_base;
               len = (job_len > N) ? N : job_len; rows = job_rows; row = 0; tref = e0;
               hold = (len != 0 && rows != 0); dedge = hold ? -1 : e0;
            end
            xen   = act && hold && cyc >= tref && cyc < tref + len;
            xaddr = xen ? (base_q + row * len + cyc - tref) % (1 << AW) : 0;
            xval  = act && hold && cyc >= tref + len + LAT;
            xbusy = act && cyc >= e0 && (dedge < 0 || cyc <= dedge);
            xdone = act && cyc == dedge;
            chk(g, "bram_en",   longint'(en_a[g]),   longint'(xen));
            chk(g, "bram_addr", longint'(addr_a[g]), longint'(xaddr));
            chk(g, "o_valid",   longint'(val_a[g]),  longint'(xval));
            chk(g, "busy",      longint'(busy_a[g]), longint'(xbusy));
            chk(g, "done",      longint'(done_a[g]), longint'(xdone));
            if (xval) begin
               for (int j = 0; j < N; j++)
                  ev[IW'(j)] = (j < len) ? mem[AW'(base_q + row * len + j)] : '0;
               chk(g, "o_row", longint'(row_a[g]), longint'(row));
               chkv(g, "o_data", data_a[g], ev);
               if (rdy) begin
                  row++; tref = cyc + 1;
                  if (row == rows) begin hold = 1'b0; dedge = cyc + 1; end
               end
            end
            if (act && dedge >= 0 && cyc > dedge) act = 1'b0;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin @(posedge clk); #2; end
   endtask

   task automatic at(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic fill(input int kind);
      for (int a = 0; a < (1 << AW); a++)
         case (kind)
            0:       mem[a] = BW'(a - 16);
            1:       mem[a] = BW'(a);
            2:       mem[a] = BW'(3 * a - 500);
            default: mem[a] = BW'(a ^ 'h0F0F);
         endcase
   endtask

   task automatic launch(input int b, input int l, input int r);
      base = AW'(b); rlen = LW'(l); nrows = RW'(r); start = 1'b1;
      job_base = b; job_len = l; job_rows = r; job_e0 = cyc + 1; job_id++;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((busy_a[0] || busy_a[1] || busy_a[2]) && n < limit) begin step(1); n++; end
      chk(0, "idle_within_budget", longint'(n < limit), 1);
      step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int e, n;
      rst = 1'b1; start = 1'b0; rdy = 1'b1; base = '0; rlen = '0; nrows = '0;
      fill(0);
      step(3); rst = 1'b0; step(2);

      // full 32-element row, all three latencies
      launch(0, 32, 1); e = job_e0;
      chk(0, "s1_addr0", longint'(addr_a[0]), 0);
      at(e + 31); chk(0, "s1_addr31", longint'(addr_a[0]), 31);
      at(e + 32); chk(0, "s1_valid_early", longint'(val_a[0]), 0);
      at(e + 33); chk(0, "s1_valid", longint'(val_a[0]), 1);
      chk(0, "s1_d0",  longint'($signed(data_a[0][0])), -16);
      chk(0, "s1_d31", longint'($signed(data_a[0][31])), 15);
      at(e + 34); chk(0, "s1_done", longint'(done_a[0]), 1);
      chk(1, "s1_valid", longint'(val_a[1]), 1);
      chk(1, "s1_d31", longint'($signed(data_a[1][31])), 15);
      at(e + 35); chk(2, "s1_valid", longint'(val_a[2]), 1);
      chk(0, "s1_done_end", longint'(done_a[0]), 0);
      wait_idle(100);

      // short rows with a stray start while busy
      fill(1);
      launch(100, 5, 3); e = job_e0;
      at(e + 2);
      start = 1'b1; base = '0; rlen = LW'(3); nrows = RW'(1);
      step(1); start = 1'b0;
      at(e + 6);  chk(0, "s2_r0_d4", longint'($signed(data_a[0][4])), 104);
      chk(0, "s2_r0_d5", longint'($signed(data_a[0][5])), 0);
      at(e + 13); chk(0, "s2_r1_row", longint'(row_a[0]), 1);
      chk(0, "s2_r1_d0", longint'($signed(data_a[0][0])), 105);
      at(e + 20); chk(0, "s2_r2_d4", longint'($signed(data_a[0][4])), 114);
      at(e + 21); chk(0, "s2_done", longint'(done_a[0]), 1);
      wait_idle(100);

      // back-pressure on row 0
      fill(2); rdy = 1'b0;
      launch(200, 8, 2);
      n = 0;
      while (!val_a[0] && n < 60) begin step(1); n++; end
      chk(0, "s3_valid_seen", longint'(val_a[0]), 1);
      for (int k = 0; k < 10; k++) begin
         step(1);
         chk(0, "s3_stall_en", longint'(en_a[0]), 0);
         chk(0, "s3_stall_d0", longint'($signed(data_a[0][0])), 100);
      end
      rdy = 1'b1;
      step(1);
      chk(0, "s3_r1_en", longint'(en_a[0]), 1);
      chk(0, "s3_r1_addr", longint'(addr_a[0]), 208);
      wait_idle(200);

      // address wrap and row_len clamp
      fill(3);
      launch(1020, 40, 1); e = job_e0;
      chk(0, "s4_addr0", longint'(addr_a[0]), 1020);
      at(e + 4);  chk(0, "s4_addr_wrap", longint'(addr_a[0]), 0);
      at(e + 31); chk(0, "s4_addr_last", longint'(addr_a[0]), 27);
      at(e + 32); chk(0, "s4_en_off", longint'(en_a[0]), 0);
      at(e + 33); chk(0, "s4_d0",  longint'($signed(data_a[0][0])), 3315);
      chk(0, "s4_d31", longint'($signed(data_a[0][31])), 3860);
      wait_idle(100);

      // degenerate launches
      launch(50, 0, 4); e = job_e0;
      chk(0, "s5_done_len0", longint'(done_a[0]), 1);
      chk(0, "s5_en_len0", longint'(en_a[0]), 0);
      at(e + 1); chk(0, "s5_busy_after", longint'(busy_a[0]), 0);
      wait_idle(20);
      launch(50, 5, 0);
      chk(0, "s5_done_rows0", longint'(done_a[0]), 1);
      wait_idle(20);

      // reset in the middle of ISSUE, then a fresh job
      fill(1);
      launch(300, 10, 2); e = job_e0;
      at(e + 3);
      rst = 1'b1; #1;
      chk(0, "s6_rst_en", longint'(en_a[0]), 0);
      chk(0, "s6_rst_busy", longint'(busy_a[0]), 0);
      chkv(0, "s6_rst_data", data_a[0], '0);
      step(2); rst = 1'b0; step(1);
      launch(100, 5, 3); e = job_e0;
      at(e + 6); chk(0, "s6_fresh_d0", longint'($signed(data_a[0][0])), 100);
      wait_idle(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
